// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the matrix-multiply sequencer: controller state
// encoding, tile-index width and the block-step count helper.
package matmul_ctrl_pkg;

  localparam int unsigned TILE_IDX_W  = 16;
  localparam int unsigned FULL_ADDR_W = 32;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    FETCH,
    LATCH,
    RUN,
    STEP,
    ACC_WAIT,
    EMIT,
    FINISH
  } state_e;

  // Block steps per output tile; a zero block size degrades to a single step.
  function automatic int unsigned calc_k(input int unsigned inner_dim,
                                         input int unsigned block_size);
    if (block_size == 0) begin
      return 1;
    end
    return inner_dim / block_size;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Row/col/k tile counters and BRAM port-B address generation.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   clr                   zero all counters
//   k_inc                 advance the block-step counter
//   tile_adv              tile complete: zero k, advance col (and row on wrap)
//   load_addr             capture addresses for the upcoming FETCH cycle
//   row, col              current tile indices (registered)
//   last_k_c, last_tile_c combinational end-of-loop flags
//   in_addr, wb_addr      registered read addresses
module matmul_addr_gen
  import matmul_ctrl_pkg::*;
#(
  parameter int unsigned K            = 2,
  parameter int unsigned ROWS         = 3,
  parameter int unsigned COLS         = 3,
  parameter int unsigned ADDR_WIDTH_I = 14,
  parameter int unsigned ADDR_WIDTH_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    k_inc,
  input  logic                    tile_adv,
  input  logic                    load_addr,
  output logic [TILE_IDX_W-1:0]   row,
  output logic [TILE_IDX_W-1:0]   col,
  output logic                    last_k_c,
  output logic                    last_tile_c,
  output logic [ADDR_WIDTH_I-1:0] in_addr,
  output logic [ADDR_WIDTH_W-1:0] wb_addr
);

  logic [TILE_IDX_W-1:0]  k;
  logic [TILE_IDX_W-1:0]  row_d;
  logic [TILE_IDX_W-1:0]  col_d;
  logic [TILE_IDX_W-1:0]  k_d;
  logic [FULL_ADDR_W-1:0] in_full;
  logic [FULL_ADDR_W-1:0] wb_full;

  assign last_k_c    = (k == TILE_IDX_W'(K - 1));
  assign last_tile_c = (row == TILE_IDX_W'(ROWS - 1)) && (col == TILE_IDX_W'(COLS - 1));

  // Next counter values; addresses are formed from these so they line up
  // with the FETCH cycle that follows.
  always_comb begin
    row_d = row;
    col_d = col;
    k_d   = k;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
    end else if (k_inc) begin
      k_d = k + TILE_IDX_W'(1);
    end else if (tile_adv) begin
      k_d = '0;
      if (col == TILE_IDX_W'(COLS - 1)) begin
        col_d = '0;
        row_d = (row == TILE_IDX_W'(ROWS - 1)) ? '0 : row + TILE_IDX_W'(1);
      end else begin
        col_d = col + TILE_IDX_W'(1);
      end
    end
  end

  // Products kept at full width; truncation happens only at the registers.
  always_comb begin
    in_full = FULL_ADDR_W'(k_d) + FULL_ADDR_W'(K) * FULL_ADDR_W'(row_d);
    wb_full = FULL_ADDR_W'(k_d) + FULL_ADDR_W'(K) * FULL_ADDR_W'(col_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      k       <= '0;
      in_addr <= '0;
      wb_addr <= '0;
    end else begin
      row <= row_d;
      col <= col_d;
      k   <= k_d;
      if (load_addr) begin
        in_addr <= ADDR_WIDTH_I'(in_full);
        wb_addr <= ADDR_WIDTH_W'(wb_full);
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Tile-level sequencer for a blocked systolic matrix multiply. Walks every
// output tile, fetching K block pairs from the input/weight BRAMs per tile,
// running the core on each pair and emitting the tile once accumulated.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start                         request a full matrix product (IDLE only)
//   busy, done                    activity level / completion pulse
//   in_enb, wb_enb                BRAM port-B enables
//   in_addrb, wb_addrb            BRAM port-B addresses
//   core_rst_n, core_en           systolic core reset / enable
//   acc_clr                       accumulator clear pulse
//   systolic_finish               core finished a block pass
//   accumulator_done              accumulator holds a complete tile
//   tile_valid, tile_row/tile_col completed tile strobe and index
module matmul_sequencer
  import matmul_ctrl_pkg::*;
#(
  parameter int unsigned INNER_DIMENSION = 4,
  parameter int unsigned BLOCK_SIZE      = 2,
  parameter int unsigned ROW_SIZE_MAT_C  = 3,
  parameter int unsigned COL_SIZE_MAT_C  = 3,
  parameter int unsigned ADDR_WIDTH_I    = 14,
  parameter int unsigned ADDR_WIDTH_W    = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    in_enb,
  output logic                    wb_enb,
  output logic [ADDR_WIDTH_I-1:0] in_addrb,
  output logic [ADDR_WIDTH_W-1:0] wb_addrb,
  output logic                    core_rst_n,
  output logic                    core_en,
  output logic                    acc_clr,
  input  logic                    systolic_finish,
  input  logic                    accumulator_done,
  output logic                    tile_valid,
  output logic [TILE_IDX_W-1:0]   tile_row,
  output logic [TILE_IDX_W-1:0]   tile_col
);

  localparam int unsigned K = calc_k(INNER_DIMENSION, BLOCK_SIZE);

  state_e                state_q;
  state_e                state_d;
  logic                  clr_c;
  logic                  k_inc_c;
  logic                  tile_adv_c;
  logic                  load_addr_c;
  logic                  last_k_c;
  logic                  last_tile_c;
  logic [TILE_IDX_W-1:0] row;
  logic [TILE_IDX_W-1:0] col;

  matmul_addr_gen #(
    .K            (K),
    .ROWS         (ROW_SIZE_MAT_C),
    .COLS         (COL_SIZE_MAT_C),
    .ADDR_WIDTH_I (ADDR_WIDTH_I),
    .ADDR_WIDTH_W (ADDR_WIDTH_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr_c),
    .k_inc       (k_inc_c),
    .tile_adv    (tile_adv_c),
    .load_addr   (load_addr_c),
    .row         (row),
    .col         (col),
    .last_k_c    (last_k_c),
    .last_tile_c (last_tile_c),
    .in_addr     (in_addrb),
    .wb_addr     (wb_addrb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter controls.
  always_comb begin
    state_d     = state_q;
    clr_c       = 1'b0;
    k_inc_c     = 1'b0;
    tile_adv_c  = 1'b0;
    load_addr_c = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = CLEAR;
      CLEAR: begin
        clr_c   = 1'b1;
        state_d = FETCH;
      end
      FETCH:    state_d = LATCH;
      LATCH:    state_d = RUN;
      RUN:      if (systolic_finish) state_d = STEP;
      STEP: begin
        if (last_k_c) begin
          state_d = ACC_WAIT;
        end else begin
          k_inc_c = 1'b1;
          state_d = FETCH;
        end
      end
      ACC_WAIT: if (accumulator_done) state_d = EMIT;
      EMIT: begin
        tile_adv_c = 1'b1;
        state_d    = last_tile_c ? FINISH : FETCH;
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    load_addr_c = (state_d == FETCH);
  end

  // Outputs are decoded from the next state so each register lines up with
  // the state it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      in_enb     <= 1'b0;
      wb_enb     <= 1'b0;
      core_en    <= 1'b0;
      core_rst_n <= 1'b0;
      acc_clr    <= 1'b0;
      tile_valid <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
    end else begin
      busy       <= (state_d != IDLE);
      done       <= (state_d == FINISH);
      in_enb     <= (state_d == FETCH);
      wb_enb     <= (state_d == FETCH);
      core_en    <= (state_d == RUN);
      core_rst_n <= !((state_d == IDLE) || (state_d == STEP) || (state_d == FINISH));
      acc_clr    <= (state_d == CLEAR) || (state_d == EMIT);
      tile_valid <= (state_d == EMIT);
      if (state_d == EMIT) begin
        tile_row <= row;
        tile_col <= col;
      end
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a default-parameter instance
// (K=2, 3x3 tiles) and a K=1, 2x2 instance, driven by a randomized core
// model and compared against a loop-nest reference of the tile walk.
module tb_matmul_sequencer;

  localparam int KA = 2;
  localparam int RA = 3;
  localparam int CA = 3;
  localparam int KB = 1;
  localparam int RB = 2;
  localparam int CB = 2;
  localparam int MAX_CYC = 3000;

  logic        clk;
  logic        rst_n;
  logic        start_drv;
  logic        start_noise;
  logic        start_a;
  logic        sf_a, ad_a;
  logic        busy_a, done_a, in_enb_a, wb_enb_a, core_rst_n_a, core_en_a, acc_clr_a, tile_valid_a;
  logic [13:0] in_addrb_a;
  logic [11:0] wb_addrb_a;
  logic [15:0] tile_row_a, tile_col_a;

  logic        start_b;
  logic        sf_b, ad_b;
  logic        busy_b, done_b, in_enb_b, wb_enb_b, core_rst_n_b, core_en_b, acc_clr_b, tile_valid_b;
  logic [13:0] in_addrb_b;
  logic [11:0] wb_addrb_b;
  logic [15:0] tile_row_b, tile_col_b;

  int n_cmp;
  int n_err;

  bit rand_lat, noise_en, ad_hold, start_spam, mon_clr;

  // Monitor records for instance A.
  int q_in[$], q_wb[$], q_trow[$], q_tcol[$], q_step_at_tile[$];
  int n_clr, n_done, n_step, n_wide;
  bit prev_low;
  // Monitor records for instance B.
  int q_in_b[$], q_wb_b[$];
  int n_tile_b, n_done_b;

  assign start_a = start_drv | start_noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matmul_sequencer dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a),
    .busy (busy_a), .done (done_a),
    .in_enb (in_enb_a), .wb_enb (wb_enb_a),
    .in_addrb (in_addrb_a), .wb_addrb (wb_addrb_a),
    .core_rst_n (core_rst_n_a), .core_en (core_en_a), .acc_clr (acc_clr_a),
    .systolic_finish (sf_a), .accumulator_done (ad_a),
    .tile_valid (tile_valid_a), .tile_row (tile_row_a), .tile_col (tile_col_a)
  );

  matmul_sequencer #(
    .INNER_DIMENSION (2), .BLOCK_SIZE (2), .ROW_SIZE_MAT_C (2), .COL_SIZE_MAT_C (2)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b),
    .busy (busy_b), .done (done_b),
    .in_enb (in_enb_b), .wb_enb (wb_enb_b),
    .in_addrb (in_addrb_b), .wb_addrb (wb_addrb_b),
    .core_rst_n (core_rst_n_b), .core_en (core_en_b), .acc_clr (acc_clr_b),
    .systolic_finish (sf_b), .accumulator_done (ad_b),
    .tile_valid (tile_valid_b), .tile_row (tile_row_b), .tile_col (tile_col_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Core model A: finish a programmable number of cycles after core_en rises;
  // random noise on the status lines whenever they must be ignored.
  initial begin
    int run_cnt;
    int lat;
    run_cnt = 0;
    lat = 2;
    sf_a = 1'b0;
    ad_a = 1'b0;
    start_noise = 1'b0;
    forever begin
      @(negedge clk);
      if (!core_en_a) begin
        run_cnt = 0;
        sf_a = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (run_cnt == 0) lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
        run_cnt++;
        sf_a = (run_cnt >= lat);
      end
      ad_a = ad_hold | ($urandom_range(0, 1) == 1);
      start_noise = start_spam & core_en_a;
    end
  end

  // Core model B.
  initial begin
    int run_cnt;
    int lat;
    run_cnt = 0;
    lat = 2;
    sf_b = 1'b0;
    ad_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!core_en_b) begin
        run_cnt = 0;
        sf_b = 1'($urandom_range(0, 1));
      end else begin
        if (run_cnt == 0) lat = int'($urandom_range(1, 3));
        run_cnt++;
        sf_b = (run_cnt >= lat);
      end
      ad_b = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitors: log fetches, tiles and pulse counts.
  initial begin
    bit low;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        q_in.delete(); q_wb.delete(); q_trow.delete(); q_tcol.delete(); q_step_at_tile.delete();
        n_clr = 0; n_done = 0; n_step = 0; n_wide = 0; prev_low = 0;
        q_in_b.delete(); q_wb_b.delete();
        n_tile_b = 0; n_done_b = 0;
      end else begin
        if (in_enb_a && wb_enb_a) begin
          q_in.push_back(int'(in_addrb_a));
          q_wb.push_back(int'(wb_addrb_a));
        end
        if (tile_valid_a) begin
          q_trow.push_back(int'(tile_row_a));
          q_tcol.push_back(int'(tile_col_a));
          q_step_at_tile.push_back(n_step);
        end
        if (acc_clr_a) n_clr++;
        if (done_a) n_done++;
        low = busy_a && !done_a && !core_rst_n_a;
        if (low) n_step++;
        if (low && prev_low) n_wide++;
        prev_low = low;
        if (in_enb_b && wb_enb_b) begin
          q_in_b.push_back(int'(in_addrb_b));
          q_wb_b.push_back(int'(wb_addrb_b));
        end
        if (tile_valid_b) n_tile_b++;
        if (done_b) n_done_b++;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
    check({tag, "_in_enb"}, 32'(in_enb_a), 0);
    check({tag, "_wb_enb"}, 32'(wb_enb_a), 0);
    check({tag, "_core_en"}, 32'(core_en_a), 0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n_a), 0);
    check({tag, "_acc_clr"}, 32'(acc_clr_a), 0);
    check({tag, "_tile_valid"}, 32'(tile_valid_a), 0);
    check({tag, "_in_addrb"}, 32'(in_addrb_a), 0);
    check({tag, "_wb_addrb"}, 32'(wb_addrb_a), 0);
    check({tag, "_tile_row"}, 32'(tile_row_a), 0);
    check({tag, "_tile_col"}, 32'(tile_col_a), 0);
  endtask

  // Reference walk for instance A compared against the monitor logs.
  task automatic compare_a(input string tag);
    int exp_in[$], exp_wb[$], exp_r[$], exp_c[$];
    int n;
    for (int r = 0; r < RA; r++)
      for (int c = 0; c < CA; c++) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
        for (int k = 0; k < KA; k++) begin
          exp_in.push_back(k + KA * r);
          exp_wb.push_back(k + KA * c);
        end
      end
    check({tag, "_fetches"}, q_in.size(), exp_in.size());
    n = (q_in.size() < exp_in.size()) ? q_in.size() : exp_in.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_in_addr%0d", tag, i), q_in[i], exp_in[i]);
      check($sformatf("%s_wb_addr%0d", tag, i), q_wb[i], exp_wb[i]);
    end
    check({tag, "_tiles"}, q_trow.size(), exp_r.size());
    n = (q_trow.size() < exp_r.size()) ? q_trow.size() : exp_r.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tile_row%0d", tag, i), q_trow[i], exp_r[i]);
      check($sformatf("%s_tile_col%0d", tag, i), q_tcol[i], exp_c[i]);
      check($sformatf("%s_steps_before_tile%0d", tag, i), q_step_at_tile[i], KA * (i + 1));
    end
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_acc_clr_pulses"}, n_clr, 1 + RA * CA);
    check({tag, "_step_pulses"}, n_step, KA * RA * CA);
    check({tag, "_step_wide"}, n_wide, 0);
  endtask

  task automatic run_a(input string tag);
    int cyc;
    clear_mon();
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < MAX_CYC) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, (cyc < MAX_CYC) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check({tag, "_idle_after"}, 32'(busy_a), 0);
    compare_a(tag);
  endtask

  task automatic run_b(input string tag);
    int cyc;
    int exp_in[$], exp_wb[$];
    clear_mon();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (n_done_b == 0 && cyc < MAX_CYC) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, (cyc < MAX_CYC) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    for (int r = 0; r < RB; r++)
      for (int c = 0; c < CB; c++)
        for (int k = 0; k < KB; k++) begin
          exp_in.push_back(k + KB * r);
          exp_wb.push_back(k + KB * c);
        end
    check({tag, "_fetches"}, q_in_b.size(), exp_in.size());
    if (q_in_b.size() == exp_in.size())
      for (int i = 0; i < exp_in.size(); i++) begin
        check($sformatf("%s_in_addr%0d", tag, i), q_in_b[i], exp_in[i]);
        check($sformatf("%s_wb_addr%0d", tag, i), q_wb_b[i], exp_wb[i]);
      end
    check({tag, "_tiles"}, n_tile_b, RB * CB);
    check({tag, "_done_pulses"}, n_done_b, 1);
    check({tag, "_idle_after"}, 32'(busy_b), 0);
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_drv = 1'b0;
    start_b = 1'b0;
    rand_lat = 1'b0;
    noise_en = 1'b0;
    ad_hold = 1'b0;
    start_spam = 1'b0;
    mon_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("por");
    check("por_b_busy", 32'(busy_b), 0);
    check("por_b_core_rst_n", 32'(core_rst_n_b), 0);
    rst_n = 1'b1;

    // Default timing: finish two cycles after core_en.
    run_a("base");

    // Randomized finish latency with noise on ignored status inputs.
    rand_lat = 1'b1;
    noise_en = 1'b1;
    for (int i = 0; i < 3; i++) run_a($sformatf("rand%0d", i));

    // start held during RUN must be ignored.
    start_spam = 1'b1;
    run_a("start_in_run");
    start_spam = 1'b0;

    // accumulator_done high throughout must not cause an early EMIT.
    ad_hold = 1'b1;
    run_a("acc_held");
    ad_hold = 1'b0;

    // Reset during tile (1,2), then restart from address 0.
    rand_lat = 1'b0;
    clear_mon();
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    cyc = 0;
    while (q_in.size() < 11 && cyc < MAX_CYC) begin
      @(posedge clk);
      cyc++;
    end
    check("midrst_timeout", (cyc < MAX_CYC) ? 1 : 0, 1);
    if (q_in.size() >= 11) begin
      check("midrst_tile12_in", q_in[10], 2);
      check("midrst_tile12_wb", q_wb[10], 4);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_a("midrst");
    rst_n = 1'b1;
    run_a("after_rst");

    // K = 1 instance.
    run_b("k1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
